// File: rtl/one_into_eight_dist.sv
// one_into_eight_dist: spreads one byte stream over eight one-deep channels A..H.
// The target channel is either the manual SEL input or a round-robin pointer (AUTO).
// Optional frame support is enabled by defining ONE_INTO_EIGHT_FRAME_EN, which adds
// the sof input and the frame_done output.

// One channel: a holding register plus its full flag.
module one_into_eight_chan #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          ack,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q,
    output logic          full
);
    // A load wins over an ack in the same cycle, so the flag stays set and the data is replaced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            full <= 1'b0;
        end else begin
            if (load) q <= d;
            if (load)
                full <= 1'b1;
            else if (ack)
                full <= 1'b0;
        end
    end
endmodule

module one_into_eight_dist #(
    parameter int DW   = 8,
    parameter int NCH  = 8,
    parameter int SELW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   din,
    input  logic            din_vld,
    output logic            din_rdy,
    input  logic            auto,
    input  logic [SELW-1:0] sel,
`ifdef ONE_INTO_EIGHT_FRAME_EN
    input  logic            sof,
    output logic            frame_done,
`endif
    output logic [DW-1:0]   a,
    output logic [DW-1:0]   b,
    output logic [DW-1:0]   c,
    output logic [DW-1:0]   d,
    output logic [DW-1:0]   e,
    output logic [DW-1:0]   f,
    output logic [DW-1:0]   g,
    output logic [DW-1:0]   h,
    output logic [NCH-1:0]  vld,
    input  logic [NCH-1:0]  ack,
    output logic [SELW-1:0] ptr
);
    logic [SELW-1:0]         tgt;
    logic                    xfer;
    logic [NCH-1:0]          load;
    logic [NCH-1:0][DW-1:0]  ch_q;

    // Pick the target channel; a start-of-frame in auto mode always restarts at A.
    always_comb begin
`ifdef ONE_INTO_EIGHT_FRAME_EN
        tgt = auto ? (sof ? '0 : ptr) : sel;
`else
        tgt = auto ? ptr : sel;
`endif
    end

    // A full target may still accept when it is being acked this same cycle.
    assign din_rdy = ~vld[tgt] | ack[tgt];
    assign xfer    = din_vld & din_rdy;

    // One-hot load strobe for the accepted beat.
    always_comb begin
        load = '0;
        if (xfer) load[tgt] = 1'b1;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        one_into_eight_chan #(.DW(DW)) u_chan (
            .clk  (clk),
            .rst  (rst),
            .load (load[i]),
            .ack  (ack[i]),
            .d    (din),
            .q    (ch_q[i]),
            .full (vld[i])
        );
    end

    assign a = ch_q[0];
    assign b = ch_q[1];
    assign c = ch_q[2];
    assign d = ch_q[3];
    assign e = ch_q[4];
    assign f = ch_q[5];
    assign g = ch_q[6];
    assign h = ch_q[7];

    // Round-robin pointer advances only on accepted auto-mode beats; wraps by width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer && auto) begin
`ifdef ONE_INTO_EIGHT_FRAME_EN
            if (sof)
                ptr <= SELW'(1);
            else
                ptr <= ptr + 1'b1;
`else
            ptr <= ptr + 1'b1;
`endif
        end
    end

`ifdef ONE_INTO_EIGHT_FRAME_EN
    // One-cycle pulse after an auto-mode beat lands in the last channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_done <= 1'b0;
        else
            frame_done <= xfer && auto && (tgt == SELW'(NCH-1));
    end
`endif
endmodule

// File: tb/tb_one_into_eight_dist.sv
// Bench for one_into_eight_dist: directed scenarios plus randomized traffic,
// all compared against a channel-array model every cycle.
module tb_one_into_eight_dist;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       din_vld = 1'b0;
    logic       din_rdy;
    logic       auto = 1'b0;
    logic [2:0] sel = '0;
    logic [7:0] a, b, c, d, e, f, g, h;
    logic [7:0] vld;
    logic [7:0] ack = '0;
    logic [2:0] ptr;
`ifdef ONE_INTO_EIGHT_FRAME_EN
    logic       sof = 1'b0;
    logic       frame_done;
`endif

    int checks = 0;
    int errors = 0;

    one_into_eight_dist dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
        .auto(auto), .sel(sel),
`ifdef ONE_INTO_EIGHT_FRAME_EN
        .sof(sof), .frame_done(frame_done),
`endif
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .vld(vld), .ack(ack), .ptr(ptr)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_data [8];
    logic [7:0] m_full;
    int         m_ptr;
    logic       m_fd;

    function automatic int m_target();
        int t;
        t = auto ? m_ptr : int'(sel);
`ifdef ONE_INTO_EIGHT_FRAME_EN
        if (auto && sof) t = 0;
`endif
        return t;
    endfunction

    function automatic logic m_ready();
        int t;
        t = m_target();
        return !m_full[t] || ack[t];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_data[i] <= '0;
            m_full <= '0;
            m_ptr  <= 0;
            m_fd   <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (din_vld && m_ready() && m_target() == i) begin
                    m_data[i] <= din;
                    m_full[i] <= 1'b1;
                end else if (ack[i]) begin
                    m_full[i] <= 1'b0;
                end
            end
            m_fd <= din_vld && m_ready() && auto && m_target() == 7;
            if (din_vld && m_ready() && auto) begin
`ifdef ONE_INTO_EIGHT_FRAME_EN
                if (sof) m_ptr <= 1;
                else     m_ptr <= (m_ptr + 1) % 8;
`else
                m_ptr <= (m_ptr + 1) % 8;
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_a", {24'd0, a}, {24'd0, m_data[0]});
            chk("model_b", {24'd0, b}, {24'd0, m_data[1]});
            chk("model_c", {24'd0, c}, {24'd0, m_data[2]});
            chk("model_d", {24'd0, d}, {24'd0, m_data[3]});
            chk("model_e", {24'd0, e}, {24'd0, m_data[4]});
            chk("model_f", {24'd0, f}, {24'd0, m_data[5]});
            chk("model_g", {24'd0, g}, {24'd0, m_data[6]});
            chk("model_h", {24'd0, h}, {24'd0, m_data[7]});
            chk("model_vld", {24'd0, vld}, {24'd0, m_full});
            chk("model_ptr", {29'd0, ptr}, m_ptr);
            chk("model_rdy", {31'd0, din_rdy}, {31'd0, m_ready()});
`ifdef ONE_INTO_EIGHT_FRAME_EN
            chk("model_fd", {31'd0, frame_done}, {31'd0, m_fd});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; din_vld = 1'b0; ack = '0; auto = 1'b0; sel = '0;
`ifdef ONE_INTO_EIGHT_FRAME_EN
        sof = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic pending;
        #1;
        chk("reset_vld", {24'd0, vld}, 32'h0);
        chk("reset_ptr", {29'd0, ptr}, 32'h0);
        chk("reset_h", {24'd0, h}, 32'h0);
        do_reset();
        chk("reset_rdy", {31'd0, din_rdy}, 32'h1);

        // 1) eight auto beats fill A..H, ninth stalls
        auto = 1'b1; din_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 8'h10 + 8'(i);
            tick();
        end
        din = 8'h18;
        chk("s1_a", {24'd0, a}, 32'h10);
        chk("s1_d", {24'd0, d}, 32'h13);
        chk("s1_h", {24'd0, h}, 32'h17);
        chk("s1_vld", {24'd0, vld}, 32'hFF);
        chk("s1_ptr", {29'd0, ptr}, 32'h0);
        chk("s1_rdy", {31'd0, din_rdy}, 32'h0);
        tick();
        chk("s1_stall_a", {24'd0, a}, 32'h10);
        chk("s1_stall_ptr", {29'd0, ptr}, 32'h0);

        // 2) ack A while the stalled beat is presented
        ack = 8'h01;
        #1 chk("s2_rdy", {31'd0, din_rdy}, 32'h1);
        tick();
        ack = '0; din_vld = 1'b0;
        chk("s2_a", {24'd0, a}, 32'h18);
        chk("s2_vld", {24'd0, vld}, 32'hFF);
        chk("s2_ptr", {29'd0, ptr}, 32'h1);

        // 3) manual mode into F
        auto = 1'b0; sel = 3'd5;
        ack = 8'h20; tick(); ack = '0;
        din = 8'hA5; din_vld = 1'b1; tick();
        din = 8'h5A;
        chk("s3_f", {24'd0, f}, 32'hA5);
        chk("s3_rdy", {31'd0, din_rdy}, 32'h0);
        tick();
        din_vld = 1'b0;
        chk("s3_f_hold", {24'd0, f}, 32'hA5);
        chk("s3_ptr", {29'd0, ptr}, 32'h1);

        // 4) acks to an empty and two full channels
        ack = 8'h08; tick();
        ack = 8'h2C; tick(); ack = '0;
        chk("s4_vld", {24'd0, vld}, 32'hD3);
        chk("s4_c", {24'd0, c}, 32'h12);
        chk("s4_f", {24'd0, f}, 32'hA5);

        // 5) asynchronous reset mid-cycle
        do_reset();
        auto = 1'b1; din_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'h30 + 8'(i);
            tick();
        end
        din_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("s5_a", {24'd0, a}, 32'h0);
        chk("s5_vld", {24'd0, vld}, 32'h0);
        chk("s5_ptr", {29'd0, ptr}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        din = 8'h77; din_vld = 1'b1; tick(); din_vld = 1'b0;
        chk("s5_after_a", {24'd0, a}, 32'h77);
        chk("s5_after_ptr", {29'd0, ptr}, 32'h1);

`ifdef ONE_INTO_EIGHT_FRAME_EN
        // 6) SOF restarts at A, frame_done after the beat into H
        do_reset();
        auto = 1'b1; din_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'h40 + 8'(i);
            tick();
        end
        din_vld = 1'b0; ack = 8'hFF; tick(); ack = '0;
        chk("s6_ptr4", {29'd0, ptr}, 32'h4);
        sof = 1'b1; din = 8'hC0; din_vld = 1'b1; tick(); sof = 1'b0;
        chk("s6_a", {24'd0, a}, 32'hC0);
        chk("s6_ptr", {29'd0, ptr}, 32'h1);
        for (int i = 1; i < 8; i++) begin
            din = 8'hC0 + 8'(i);
            tick();
            if (i < 7) chk("s6_fd_low", {31'd0, frame_done}, 32'h0);
        end
        din_vld = 1'b0;
        chk("s6_fd_high", {31'd0, frame_done}, 32'h1);
        chk("s6_h", {24'd0, h}, 32'hC7);
        tick();
        chk("s6_fd_pulse", {31'd0, frame_done}, 32'h0);
`endif

        // randomized traffic; a stalled beat is held until accepted
        do_reset();
        pending = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (!pending) begin
                din     = 8'($urandom);
                din_vld = ($urandom_range(0, 3) != 0);
            end
            auto = ($urandom_range(0, 3) != 0);
            sel  = 3'($urandom);
            ack  = 8'($urandom) & 8'($urandom);
`ifdef ONE_INTO_EIGHT_FRAME_EN
            sof  = ($urandom_range(0, 15) == 0);
`endif
            #2 pending = din_vld && !din_rdy;
            tick();
        end
        din_vld = 1'b0; ack = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
